// File: rtl/product_bcd_pkg.sv
// Shared types and helpers for the product-to-BCD display converter.
// Optional leading-zero blanking is enabled by LEADING_ZERO_BLANK_EN.
package product_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } conv_state_t;

  localparam int BCD_DIGIT_W = 4;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bcd_dabble_cell.sv
// Double-dabble digit correction: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_dabble_cell
  import product_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_in,
  output logic [BCD_DIGIT_W-1:0] d_out
);

  always_comb begin
    d_out = d_in;
    if (d_in >= BCD_DIGIT_W'(5)) begin
      d_out = d_in + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/product_bcd_converter.sv
// Sign + BCD converter for the multiplier product, one bit per clock.
// Define LEADING_ZERO_BLANK_EN to drive leading-zero blank flags.
module product_bcd_converter
  import product_bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 1
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Start,
  input  logic [WIDTH-1:0]              Product,
  output logic                          Busy,
  output logic                          Done,
  output logic                          Neg,
  output logic [BCD_DIGIT_W*DIGITS-1:0] Bcd,
  output logic [DIGITS-1:0]             DigitBlank
);

  localparam int CW = cnt_w(WIDTH);
  localparam int BW = BCD_DIGIT_W * DIGITS;

  conv_state_t       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  mag_q, mag_d;
  logic [BW-1:0]     scr_q, scr_d;
  logic              negp_q, negp_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              neg_q, neg_d;
  logic [DIGITS-1:0] blank_q, blank_d;

  logic [BW-1:0]     adj;
  logic [BW-1:0]     shifted;
  logic [DIGITS-1:0] lz_blank;
  logic              sgn;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_dabble_cell u_cell (
      .d_in  (scr_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_out (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign shifted = {adj[BW-2:0], mag_q[WIDTH-1]};
  assign sgn     = (SIGNED != 0) && Product[WIDTH-1];

`ifdef LEADING_ZERO_BLANK_EN
  logic seen;

  // Blank every digit above the most significant nonzero one.
  always_comb begin
    lz_blank = '0;
    seen     = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (shifted[i*BCD_DIGIT_W +: BCD_DIGIT_W] != '0) begin
        seen = 1'b1;
      end
      lz_blank[i] = ~seen;
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    scr_d   = scr_q;
    negp_d  = negp_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    blank_d = blank_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = CONVERT;
          cnt_d   = CW'(WIDTH);
          scr_d   = '0;
          negp_d  = sgn;
          mag_d   = sgn ? (~Product + WIDTH'(1)) : Product;
        end
      end
      CONVERT: begin
        scr_d = shifted;
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        // Final shift: publish the finished digits for the DONE cycle.
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          bcd_d   = shifted;
          neg_d   = negp_q;
          blank_d = lz_blank;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      scr_q   <= '0;
      negp_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      scr_q   <= scr_d;
      negp_q  <= negp_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      blank_q <= blank_d;
    end
  end

  assign Busy       = (state_q != IDLE);
  assign Done       = (state_q == DONE);
  assign Neg        = neg_q;
  assign Bcd        = bcd_q;
  assign DigitBlank = blank_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Bench for product_bcd_converter: signed and unsigned instances
// against a decimal-arithmetic reference model.
module tb_product_bcd_converter;

  localparam int LAT = 17;

  logic        clk;
  logic        Reset;
  logic        Start;
  logic [15:0] Product;

  logic        busy_s, done_s, neg_s;
  logic [19:0] bcd_s;
  logic [4:0]  blank_s;
  logic        busy_u, done_u, neg_u;
  logic [19:0] bcd_u;
  logic [4:0]  blank_u;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int done_cnt = 0;
  bit chk_en   = 0;

  int          m_rem = 0;
  logic [15:0] m_prod;
  logic [19:0] es_bcd = '0, eu_bcd = '0;
  logic        es_neg = 1'b0;
  logic [4:0]  es_blank = '0, eu_blank = '0;

  product_bcd_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) u_dut (
    .Clk(clk), .Reset(Reset), .Start(Start), .Product(Product),
    .Busy(busy_s), .Done(done_s), .Neg(neg_s), .Bcd(bcd_s),
    .DigitBlank(blank_s)
  );

  product_bcd_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u_dut_u (
    .Clk(clk), .Reset(Reset), .Start(Start), .Product(Product),
    .Busy(busy_u), .Done(done_u), .Neg(neg_u), .Bcd(bcd_u),
    .DigitBlank(blank_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] blank_of(input logic [19:0] b);
    logic [4:0] r;
    r = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      int top;
      top = 0;
      for (int i = 0; i < 5; i++)
        if (b[4*i +: 4] != 4'd0) top = i;
      for (int i = 1; i < 5; i++) r[i] = (i > top);
    end
`else
    r = b[4:0] & 5'b0;
`endif
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: a conversion occupies LAT busy cycles, the last is Done.
  always @(posedge clk) begin
    if (!Reset) begin
      m_rem    = 0;
      es_bcd   = '0;
      es_neg   = 1'b0;
      es_blank = '0;
      eu_bcd   = '0;
      eu_blank = '0;
    end else if (m_rem == 0) begin
      if (Start) begin
        m_rem  = LAT;
        m_prod = Product;
      end
    end else begin
      m_rem--;
      if (m_rem == 1) begin
        int sv;
        sv       = int'($signed(m_prod));
        es_neg   = (sv < 0);
        es_bcd   = to_bcd(es_neg ? -sv : sv);
        es_blank = blank_of(es_bcd);
        eu_bcd   = to_bcd(int'(m_prod));
        eu_blank = blank_of(eu_bcd);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",    busy_s,  m_rem != 0);
      check("done",    done_s,  m_rem == 1);
      check("neg",     neg_s,   es_neg);
      check("bcd",     bcd_s,   es_bcd);
      check("blank",   blank_s, es_blank);
      check("u_busy",  busy_u,  m_rem != 0);
      check("u_done",  done_u,  m_rem == 1);
      check("u_neg",   neg_u,   1'b0);
      check("u_bcd",   bcd_u,   eu_bcd);
      check("u_blank", blank_u, eu_blank);
      if (done_s) done_cnt++;
    end
  end

  task automatic run_conv(input logic [15:0] p, input logic [19:0] eb,
                          input logic en, input logic [19:0] eub);
    int n;
    Start   = 1'b1;
    Product = p;
    @(negedge clk);
    Start   = 1'b0;
    Product = 16'($urandom);
    n = 1;
    while (!done_s && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, LAT);
    check("lit_bcd", bcd_s, eb);
    check("lit_neg", neg_s, en);
    check("lit_ubcd", bcd_u, eub);
    @(negedge clk);
  endtask

  initial begin
    int d0;
    Reset   = 1'b0;
    Start   = 1'b0;
    Product = '0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    check("rst_bcd", bcd_s, 20'h0);
    check("rst_busy", busy_s, 1'b0);
    Reset = 1'b1;
    @(negedge clk);

    run_conv(16'h0000, 20'h00000, 1'b0, 20'h00000);
    run_conv(16'h00FF, 20'h00255, 1'b0, 20'h00255);
`ifdef LEADING_ZERO_BLANK_EN
    check("lit_blank_ff", blank_s, 5'b11000);
`else
    check("lit_blank_ff", blank_s, 5'b00000);
`endif
    run_conv(16'hFFFF, 20'h00001, 1'b1, 20'h65535);
    run_conv(16'h8000, 20'h32768, 1'b1, 20'h32768);
    run_conv(16'h7FFF, 20'h32767, 1'b0, 20'h32767);

    // Start pulse during CONVERT must be dropped.
    Start   = 1'b1;
    Product = 16'h0005;
    @(negedge clk);
    Start   = 1'b0;
    Product = 16'($urandom);
    repeat (4) @(negedge clk);
    Start   = 1'b1;
    Product = 16'h1234;
    @(negedge clk);
    Start = 1'b0;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("ignored_dones", done_cnt - d0, 1);
    check("ignored_bcd", bcd_s, 20'h00005);
    run_conv(16'h1234, 20'h04660, 1'b0, 20'h04660);

    // Reset in the middle of a conversion.
    Start   = 1'b1;
    Product = 16'h7FFF;
    @(negedge clk);
    Start = 1'b0;
    repeat (7) @(negedge clk);
    Reset = 1'b0;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    check("abort_busy", busy_s, 1'b0);
    check("abort_bcd", bcd_s, 20'h0);
    Reset = 1'b1;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("abort_dones", done_cnt - d0, 0);
    run_conv(16'h0064, 20'h00100, 1'b0, 20'h00100);

    // Start held high: back-to-back conversions.
    d0 = done_cnt;
    Start = 1'b1;
    repeat (54) begin
      Product = 16'($urandom);
      @(negedge clk);
    end
    Start = 1'b0;
    repeat (20) @(negedge clk);
    check("b2b_dones", done_cnt - d0, 3);

    // Random traffic with occasional resets.
    repeat (3000) begin
      Start   = ($urandom_range(5) == 0);
      Product = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom);
      Reset   = ($urandom_range(199) != 0);
      @(negedge clk);
    end
    Reset = 1'b1;
    Start = 1'b0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
